// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding and stream framing constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    CHECK = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int unsigned LANES = 4;

  function automatic logic is_ready_state(input state_t s);
    return s inside {HDR0, HDR1, DATA};
  endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Four-lane byte assembler: collects stream bytes into a little-endian
// 32-bit word, one lane per write, cleared once the word is consumed.
module imem_loader_asm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        lane_we,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  logic [LANES-1:0][7:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (lane_we) begin
      word_d[lane] = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length header, streams 32-bit words into instruction
// memory and holds the CPU in reset until the whole image is written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned TAM   = 1023,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] word_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             ready_q, ready_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;
  logic             asm_we;
  logic             asm_clr;
  logic [31:0]      asm_word;

  assign xfer = byte_valid & ready_q;

  imem_loader_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (asm_clr),
    .lane_we (asm_we),
    .lane    (idx_q),
    .din     (byte_data),
    .word    (asm_word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    asm_we  = 1'b0;
    asm_clr = 1'b0;
    case (state_q)
      HDR0: if (xfer) begin
        len_d[7:0] = byte_data;
        state_d    = HDR1;
      end
      HDR1: if (xfer) begin
        len_d[15:8] = byte_data;
        state_d     = CHECK;
      end
      CHECK: begin
        if (len_q == '0)                 state_d = DONE;
        else if (32'(len_q) > TAM + 1)   state_d = ERR;
        else                             state_d = DATA;
      end
      DATA: if (xfer) begin
        asm_we = 1'b1;
        idx_d  = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        asm_clr = 1'b1;
        state_d = (cnt_d == len_q) ? DONE : DATA;
      end
      default: state_d = state_q;
    endcase
    // Status outputs are registered from the next state so they change on
    // the same edge that enters DONE/ERR.
    ready_d   = is_ready_state(state_d);
    cpu_rst_d = (state_d != DONE);
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HDR0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign im_we      = (state_q == WRITE);
  assign im_addr    = im_we ? 32'({cnt_q, 2'b00}) : '0;
  assign im_wdata   = im_we ? asm_word : '0;
  assign byte_ready = ready_q;
  assign cpu_reset  = cpu_rst_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_count = cnt_q;

endmodule
